// File: rtl/instr_encoder.sv
// RV32I instruction encoder: two-stage valid/ready pipeline.
// Stage A holds the request and range-checks the immediate; stage B holds the packed word.
module instr_encoder #(
    parameter int ERR_CNT_W  = 8,
    parameter bit NOP_ON_ERR = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [2:0]           fmt_i,
    input  logic [6:0]           opcode_i,
    input  logic [4:0]           rd_i,
    input  logic [4:0]           rs1_i,
    input  logic [4:0]           rs2_i,
    input  logic [2:0]           funct3_i,
    input  logic [6:0]           funct7_i,
    input  logic [31:0]          imm_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [31:0]          instr_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam logic [2:0]  FMT_R = 3'd0;
    localparam logic [2:0]  FMT_I = 3'd1;
    localparam logic [2:0]  FMT_S = 3'd2;
    localparam logic [2:0]  FMT_B = 3'd3;
    localparam logic [2:0]  FMT_U = 3'd4;
    localparam logic [2:0]  FMT_J = 3'd5;
    localparam logic [31:0] ERR_WORD = NOP_ON_ERR ? 32'h0000_0013 : 32'h0000_0000;
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic                 validA_q, validA_d;
    logic [2:0]           fmtA_q;
    logic [6:0]           opcodeA_q;
    logic [4:0]           rdA_q, rs1A_q, rs2A_q;
    logic [2:0]           funct3A_q;
    logic [6:0]           funct7A_q;
    logic [31:0]          immA_q;

    logic                 validB_q, validB_d;
    logic [31:0]          instrB_q, instrB_d;
    logic                 errB_q, errB_d;
    logic [ERR_CNT_W-1:0] errCnt_q, errCnt_d;

    logic advB, acceptIn, moveAB, outFire;
    logic errA;
    logic [31:0] packedA;

    assign advB       = !validB_q || out_ready_i;
    assign in_ready_o = !validA_q || advB;
    assign acceptIn   = in_valid_i && in_ready_o;
    assign moveAB     = validA_q && advB;
    assign outFire    = validB_q && out_ready_i;

    // A value fits in N signed bits when everything from bit N-1 upward is a pure sign extension.
    always_comb begin
        errA = 1'b0;
        case (fmtA_q)
            FMT_R:        errA = 1'b0;
            FMT_I, FMT_S: errA = !((immA_q[31:11] == '0) || (immA_q[31:11] == '1));
            FMT_B:        errA = !((immA_q[31:12] == '0) || (immA_q[31:12] == '1)) || immA_q[0];
            FMT_U:        errA = (immA_q[11:0] != 12'h000);
            FMT_J:        errA = !((immA_q[31:20] == '0) || (immA_q[31:20] == '1)) || immA_q[0];
            default:      errA = 1'b1;
        endcase
    end

    always_comb begin
        packedA = ERR_WORD;
        case (fmtA_q)
            FMT_R: packedA = {funct7A_q, rs2A_q, rs1A_q, funct3A_q, rdA_q, opcodeA_q};
            FMT_I: packedA = {immA_q[11:0], rs1A_q, funct3A_q, rdA_q, opcodeA_q};
            FMT_S: packedA = {immA_q[11:5], rs2A_q, rs1A_q, funct3A_q, immA_q[4:0], opcodeA_q};
            FMT_B: packedA = {immA_q[12], immA_q[10:5], rs2A_q, rs1A_q, funct3A_q,
                              immA_q[4:1], immA_q[11], opcodeA_q};
            FMT_U: packedA = {immA_q[31:12], rdA_q, opcodeA_q};
            FMT_J: packedA = {immA_q[20], immA_q[10:1], immA_q[11], immA_q[19:12],
                              rdA_q, opcodeA_q};
            default: packedA = ERR_WORD;
        endcase
    end

    always_comb begin
        validA_d = validA_q;
        validB_d = validB_q;
        instrB_d = instrB_q;
        errB_d   = errB_q;
        errCnt_d = errCnt_q;
        if (acceptIn) begin
            validA_d = 1'b1;
        end else if (moveAB) begin
            validA_d = 1'b0;
        end
        if (moveAB) begin
            validB_d = 1'b1;
            instrB_d = errA ? ERR_WORD : packedA;
            errB_d   = errA;
        end else if (outFire) begin
            validB_d = 1'b0;
        end
        // Saturate rather than wrap so a long run of bad entries never reads as few.
        if (outFire && errB_q && (errCnt_q != '1)) begin
            errCnt_d = errCnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            validA_q  <= 1'b0;
            fmtA_q    <= 3'd0;
            opcodeA_q <= 7'd0;
            rdA_q     <= 5'd0;
            rs1A_q    <= 5'd0;
            rs2A_q    <= 5'd0;
            funct3A_q <= 3'd0;
            funct7A_q <= 7'd0;
            immA_q    <= 32'd0;
            validB_q  <= 1'b0;
            instrB_q  <= 32'd0;
            errB_q    <= 1'b0;
            errCnt_q  <= '0;
        end else begin
            validA_q <= validA_d;
            validB_q <= validB_d;
            instrB_q <= instrB_d;
            errB_q   <= errB_d;
            errCnt_q <= errCnt_d;
            if (acceptIn) begin
                fmtA_q    <= fmt_i;
                opcodeA_q <= opcode_i;
                rdA_q     <= rd_i;
                rs1A_q    <= rs1_i;
                rs2A_q    <= rs2_i;
                funct3A_q <= funct3_i;
                funct7A_q <= funct7_i;
                immA_q    <= imm_i;
            end
        end
    end

    assign out_valid_o = validB_q;
    assign instr_o     = instrB_q;
    assign err_o       = errB_q;
    assign err_cnt_o   = errCnt_q;

endmodule
